fml_bram_slave: RTL and testbench



---
 rtl/fml_pkg.sv | 16 +
 rtl/fml_bram_sp.sv | 35 +++
 rtl/fml_bram_slave.sv | 121 ++++++++++++
 tb/tb_fml_bram_slave.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fml_pkg.sv
// Shared FML definitions: responder states, burst geometry and beat-counter width.
package fml_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACK,
      WBURST,
      RBURST
   } fml_state_e;

   localparam int FML_BURST_LEN = 4;
   localparam int FML_DATA_W    = 16;
   localparam int FML_BEAT_W    = $clog2(FML_BURST_LEN);

endpackage

// File: rtl/fml_bram_sp.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module fml_bram_sp
   import fml_pkg::*;
#(
   parameter int mem_aw = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  we,
   input  logic [1:0]            sel,
   input  logic [mem_aw-1:0]     addr,
   input  logic [FML_DATA_W-1:0] wdata,
   output logic [FML_DATA_W-1:0] rdata
);

   logic [7:0] mem_hi [2**mem_aw];
   logic [7:0] mem_lo [2**mem_aw];

   always_ff @(posedge clk) begin
      if (en && we) begin
         if (sel[1]) mem_hi[addr] <= wdata[15:8];
         if (sel[0]) mem_lo[addr] <= wdata[7:0];
      end
   end

   // Only the read register is reset; array contents survive reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rdata <= '0;
      else if (en && !we)
         rdata <= {mem_hi[addr], mem_lo[addr]};
   end

endmodule

// File: rtl/fml_bram_slave.sv
// FML responder backed by block RAM: 4-beat 16-bit bursts after programmable wait states.
// Define FML_BRAM_SLAVE_STATS_EN to add rd_bursts/wr_bursts burst counters.
module fml_bram_slave
   import fml_pkg::*;
#(
   parameter int fml_depth   = 26,
   parameter int mem_aw      = 12,
   parameter int wait_states = 2
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [fml_depth-1:0]  fml_adr,
   input  logic                  fml_stb,
   input  logic                  fml_we,
   output logic                  fml_ack,
   input  logic [1:0]            fml_sel,
   input  logic [FML_DATA_W-1:0] fml_di,
   output logic [FML_DATA_W-1:0] fml_do
`ifdef FML_BRAM_SLAVE_STATS_EN
   ,
   output logic [31:0]           rd_bursts,
   output logic [31:0]           wr_bursts
`endif
);

   localparam logic [3:0] WAIT_LOAD = (wait_states > 0) ? 4'(wait_states - 1) : '0;

   fml_state_e            state;
   logic [mem_aw-3:0]     base;
   logic                  we_q;
   logic [FML_BEAT_W-1:0] cnt;
   logic [3:0]            wcnt;

   logic                  ram_en;
   logic                  ram_we;
   logic [mem_aw-1:0]     ram_addr;

   logic                  unused_adr;
   assign unused_adr = ^{fml_adr[fml_depth-1:mem_aw+1], fml_adr[2:0]};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= IDLE;
         base    <= '0;
         we_q    <= 1'b0;
         cnt     <= '0;
         wcnt    <= '0;
         fml_ack <= 1'b0;
`ifdef FML_BRAM_SLAVE_STATS_EN
         rd_bursts <= '0;
         wr_bursts <= '0;
`endif
      end else begin
         fml_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (fml_stb) begin
                  base <= fml_adr[mem_aw:3];
                  we_q <= fml_we;
                  cnt  <= '0;
                  if (wait_states > 0) begin
                     wcnt  <= WAIT_LOAD;
                     state <= WAIT;
                  end else begin
                     state   <= ACK;
                     fml_ack <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (!fml_stb) begin
                  state <= IDLE;
               end else if (wcnt == '0) begin
                  state   <= ACK;
                  fml_ack <= 1'b1;
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            ACK: begin
               cnt   <= cnt + 1'b1;
               state <= we_q ? WBURST : RBURST;
`ifdef FML_BRAM_SLAVE_STATS_EN
               if (we_q) wr_bursts <= wr_bursts + 32'd1;
               else      rd_bursts <= rd_bursts + 32'd1;
`endif
            end
            // Reads run one beat ahead of fml_do, so both bursts end after beat 3 is issued.
            WBURST, RBURST: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = {base, cnt};
      if (state == ACK || state == WBURST || state == RBURST) begin
         ram_en = 1'b1;
         ram_we = we_q;
      end
   end

   fml_bram_sp #(
      .mem_aw(mem_aw)
   ) u_ram (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .en    (ram_en),
      .we    (ram_we),
      .sel   (fml_sel),
      .addr  (ram_addr),
      .wdata (fml_di),
      .rdata (fml_do)
   );

endmodule

// File: tb/tb_fml_bram_slave.sv
// Directed bench for fml_bram_slave (wait_states=2, mem_aw=12); covers counters when FML_BRAM_SLAVE_STATS_EN is set.
module tb_fml_bram_slave;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [25:0] fml_adr;
   logic        fml_stb;
   logic        fml_we;
   logic        fml_ack;
   logic [1:0]  fml_sel;
   logic [15:0] fml_di;
   logic [15:0] fml_do;
`ifdef FML_BRAM_SLAVE_STATS_EN
   logic [31:0] rd_bursts;
   logic [31:0] wr_bursts;
`endif

   int vectors;
   int miscompares;
   int cyc;
   int last_ack;

   fml_bram_slave #(
      .fml_depth   (26),
      .mem_aw      (12),
      .wait_states (2)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .fml_adr   (fml_adr),
      .fml_stb   (fml_stb),
      .fml_we    (fml_we),
      .fml_ack   (fml_ack),
      .fml_sel   (fml_sel),
      .fml_di    (fml_di),
      .fml_do    (fml_do)
`ifdef FML_BRAM_SLAVE_STATS_EN
      ,
      .rd_bursts (rd_bursts),
      .wr_bursts (wr_bursts)
`endif
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial cyc = 0;
   always @(posedge sys_clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pulse_reset(input string tag);
      sys_rst_n = 1'b0;
      #1;
      check({tag, " ack in reset"}, 32'(fml_ack), 32'd0);
      check({tag, " do in reset"}, 32'(fml_do), 32'd0);
`ifdef FML_BRAM_SLAVE_STATS_EN
      check({tag, " rd_bursts in reset"}, rd_bursts, 32'd0);
      check({tag, " wr_bursts in reset"}, wr_bursts, 32'd0);
`endif
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   // Starts at a negedge; stb is sampled at the following posedge when the DUT is idle.
   // exp_lat=0 skips the latency check; rst_after>=0 resets after that write beat lands.
   task automatic burst(input string tag, input logic [25:0] adr, input logic we,
                        input logic [7:0] sel, input logic [63:0] data,
                        input int exp_lat, input int rst_after);
      int lat;
      fml_adr = adr;
      fml_we  = we;
      fml_stb = 1'b1;
      fml_sel = sel[1:0];
      fml_di  = data[15:0];
      lat = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge sys_clk);
         if (fml_ack) begin
            lat = i;
            break;
         end
      end
      fml_stb = 1'b0;
      if (lat == 0) begin
         check({tag, " ack timeout"}, 32'd0, 32'd1);
         return;
      end
      last_ack = cyc;
      if (exp_lat != 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      if (we) begin
         for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            if (k == 1) check({tag, " ack one cycle"}, 32'(fml_ack), 32'd0);
            if (k == rst_after + 1) begin
               pulse_reset(tag);
               return;
            end
            if (k < 4) begin
               fml_sel = sel[2*k +: 2];
               fml_di  = data[16*k +: 16];
            end
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            if (k == 0) check({tag, " ack one cycle"}, 32'(fml_ack), 32'd0);
            check($sformatf("%s beat%0d", tag, k), 32'(fml_do), 32'(data[16*k +: 16]));
         end
      end
   endtask

   initial begin
      int prev;
      int acks;
      vectors     = 0;
      miscompares = 0;
      last_ack    = 0;
      sys_rst_n   = 1'b0;
      fml_adr     = '0;
      fml_stb     = 1'b0;
      fml_we      = 1'b0;
      fml_sel     = 2'b00;
      fml_di      = '0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("reset ack", 32'(fml_ack), 32'd0);
      check("reset do", 32'(fml_do), 32'd0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      // Basic write then read
      burst("t1 wr", 26'h0010, 1'b1, 8'hFF, 64'h4444_3333_2222_1111, 3, -1);
      @(negedge sys_clk);
      burst("t1 rd", 26'h0010, 1'b0, 8'h00, 64'h4444_3333_2222_1111, 3, -1);
      @(negedge sys_clk);

      // Byte enables: only the low lane of beat 0 changes
      burst("t2 pre", 26'h0010, 1'b1, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 3, -1);
      @(negedge sys_clk);
      burst("t2 wr", 26'h0010, 1'b1, 8'h01, 64'h0000_0000_0000_0055, 3, -1);
      @(negedge sys_clk);
      burst("t2 rd", 26'h0010, 1'b0, 8'h00, 64'hAAAA_AAAA_AAAA_AA55, 3, -1);
      @(negedge sys_clk);

      // Unaligned and aliased addresses, plus a neighbouring block
      burst("t3 wr18", 26'h0018, 1'b1, 8'hFF, 64'h8888_7777_6666_5555, 3, -1);
      @(negedge sys_clk);
      burst("t3 rd16", 26'h0016, 1'b0, 8'h00, 64'hAAAA_AAAA_AAAA_AA55, 3, -1);
      @(negedge sys_clk);
      burst("t3 rd2010", 26'h2010, 1'b0, 8'h00, 64'hAAAA_AAAA_AAAA_AA55, 3, -1);
      @(negedge sys_clk);
      burst("t3 rd18", 26'h0018, 1'b0, 8'h00, 64'h8888_7777_6666_5555, 3, -1);
      @(negedge sys_clk);

      // Abort: strobe dropped during the wait states
      fml_adr = 26'h0010;
      fml_we  = 1'b1;
      fml_sel = 2'b11;
      fml_di  = 16'hDEAD;
      fml_stb = 1'b1;
      @(negedge sys_clk);
      fml_stb = 1'b0;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         if (fml_ack) acks++;
      end
      check("t4 abort acks", 32'(acks), 32'd0);
      burst("t4 rd", 26'h0010, 1'b0, 8'h00, 64'hAAAA_AAAA_AAAA_AA55, 3, -1);
      @(negedge sys_clk);

      // Reset after beat 1 of a write burst
      burst("t5 wr", 26'h0010, 1'b1, 8'hFF, 64'h5504_5503_5502_5501, 3, 1);
      @(negedge sys_clk);
      burst("t5 rd", 26'h0010, 1'b0, 8'h00, 64'hAAAA_AAAA_5502_5501, 3, -1);
      @(negedge sys_clk);

      // Back-to-back bursts at minimum spacing
      pulse_reset("t6");
      @(negedge sys_clk);
      burst("t6 w0", 26'h0040, 1'b1, 8'hFF, 64'h0D04_0C03_0B02_0A01, 3, -1);
      prev = last_ack;
      burst("t6 w1", 26'h0048, 1'b1, 8'hFF, 64'h1D14_1C13_1B12_1A11, 0, -1);
      check("t6 spacing w1", 32'(last_ack - prev), 32'd7);
      prev = last_ack;
      burst("t6 w2", 26'h0050, 1'b1, 8'hFF, 64'h2D24_2C23_2B22_2A21, 0, -1);
      check("t6 spacing w2", 32'(last_ack - prev), 32'd7);
      prev = last_ack;
      burst("t6 r0", 26'h0040, 1'b0, 8'h00, 64'h0D04_0C03_0B02_0A01, 0, -1);
      check("t6 spacing r0", 32'(last_ack - prev), 32'd7);
      prev = last_ack;
      burst("t6 r1", 26'h0050, 1'b0, 8'h00, 64'h2D24_2C23_2B22_2A21, 0, -1);
      check("t6 spacing r1", 32'(last_ack - prev), 32'd7);
      @(negedge sys_clk);
`ifdef FML_BRAM_SLAVE_STATS_EN
      check("t6 wr_bursts", wr_bursts, 32'd3);
      check("t6 rd_bursts", rd_bursts, 32'd2);
`endif
      check("idle ack", 32'(fml_ack), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
